// File: rtl/lfsr_pkg.sv
// Shared types and constants for the LFSR run controller.
package lfsr_pkg;

  localparam int unsigned LFSR_W  = 4;
  localparam int unsigned COUNT_W = 5;

  // Feedback taps for x^4 + x^3 + 1: bits 3 and 2.
  localparam logic [LFSR_W-1:0] TAP = 4'b1100;

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StRun,
    StDone
  } state_e;

  // One Fibonacci step: shift left, feed back the XOR of the tapped bits.
  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] q);
    return {q[LFSR_W-2:0], ^(q & TAP)};
  endfunction

endpackage

// File: rtl/lfsr_core.sv
// 4-bit Fibonacci LFSR register with parallel load and step enable.
module lfsr_core
  import lfsr_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [LFSR_W-1:0] load_val,
  input  logic              en,
  output logic [LFSR_W-1:0] q
);

  // Load wins over step; reset wins over both.
  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else if (load) begin
      q <= load_val;
    end else if (en) begin
      q <= lfsr_next(q);
    end
  end

endmodule

// File: rtl/lfsr_ctrl.sv
// Run controller: accepts a seed/length request, emits that many LFSR words.
module lfsr_ctrl
  import lfsr_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [LFSR_W-1:0] seed,
  input  logic [3:0]        len,
  input  logic              pause,
  output logic              busy,
  output logic [LFSR_W-1:0] out,
  output logic              out_valid,
  output logic              done,
  output logic              err
);

  state_e             state;
  logic [LFSR_W-1:0]  seed_q;
  logic [COUNT_W-1:0] count;
  // LOAD spans two cycles: the LFSR is written on the first, RUN follows the second.
  logic               load_wait;
  logic               lfsr_load;
  logic [LFSR_W-1:0]  lfsr_q;

  assign out_valid = (state == StRun) && !pause;
  assign lfsr_load = (state == StLoad) && !load_wait;
  assign out       = lfsr_q;

  lfsr_core u_core (
    .clk      (clk),
    .rst      (rst),
    .load     (lfsr_load),
    .load_val (seed_q),
    .en       (out_valid),
    .q        (lfsr_q)
  );

  // Control FSM with registered busy/done/err.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= StIdle;
      seed_q    <= '0;
      count     <= '0;
      load_wait <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        StIdle: begin
          if (start) begin
            if (seed != '0) begin
              state     <= StLoad;
              seed_q    <= seed;
              count     <= (len == 4'd0) ? COUNT_W'(16) : COUNT_W'(len);
              load_wait <= 1'b0;
              busy      <= 1'b1;
              err       <= 1'b0;
            end else begin
              // Zero seed would lock the LFSR at 0; refuse it.
              err <= 1'b1;
            end
          end
        end
        StLoad: begin
          if (!load_wait) begin
            load_wait <= 1'b1;
          end else begin
            load_wait <= 1'b0;
            state     <= StRun;
          end
        end
        StRun: begin
          if (!pause) begin
            count <= count - COUNT_W'(1);
            if (count == COUNT_W'(1)) begin
              state <= StDone;
              done  <= 1'b1;
            end
          end
        end
        StDone: begin
          state <= StIdle;
          busy  <= 1'b0;
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_lfsr_ctrl.sv
// Directed bench for lfsr_ctrl with hand-computed LFSR word sequences.
module tb_lfsr_ctrl;

  logic       clk;
  logic       rst;
  logic       start;
  logic [3:0] seed;
  logic [3:0] len;
  logic       pause;
  logic       busy;
  logic [3:0] out;
  logic       out_valid;
  logic       done;
  logic       err;

  int vectors;
  int errors;

  // Results of the most recent collect() call; cycle 1 follows the accept edge.
  logic [3:0] got_words [32];
  int         got_n;
  int         first_valid_cyc;
  int         done_cyc;
  int         done_count;
  logic       busy_after;
  logic [3:0] out_after;

  lfsr_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .seed      (seed),
    .len       (len),
    .pause     (pause),
    .busy      (busy),
    .out       (out),
    .out_valid (out_valid),
    .done      (done),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  // Step through a run started by the caller, logging words and the done pulse.
  task automatic collect(input int max_cyc, input int pause_at, input int pause_cyc,
                         input bit noise);
    int paused;
    paused          = 0;
    got_n           = 0;
    first_valid_cyc = -1;
    done_cyc        = -1;
    done_count      = 0;
    busy_after      = 1'b1;
    out_after       = 4'h0;
    for (int c = 1; c <= max_cyc; c++) begin
      @(posedge clk);
      #1;
      if (noise && !done && done_cyc < 0) begin
        start = 1'b1;
        seed  = 4'h5;
        len   = 4'h7;
      end else begin
        start = 1'b0;
      end
      if (got_n == pause_at && paused < pause_cyc) begin
        pause = 1'b1;
        paused++;
      end else begin
        pause = 1'b0;
      end
      #1;
      if (out_valid) begin
        if (first_valid_cyc < 0) first_valid_cyc = c;
        if (got_n < 32) got_words[got_n] = out;
        got_n++;
      end
      if (done) begin
        done_count++;
        if (done_cyc < 0) done_cyc = c;
      end
      if (done_cyc >= 0 && c == done_cyc + 1) begin
        busy_after = busy;
        out_after  = out;
        break;
      end
    end
    start = 1'b0;
    pause = 1'b0;
  endtask

  task automatic test_reset();
    rst   = 1'b1;
    start = 1'b1;
    seed  = 4'h1;
    len   = 4'h4;
    pause = 1'b1;
    cycle();
    cycle();
    vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    vectors++; if (out !== 4'h0) begin errors++; $display("FAIL reset_out: got %h want 0", out); end
    vectors++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", out_valid); end
    vectors++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
    vectors++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", err); end
    rst   = 1'b0;
    start = 1'b0;
    pause = 1'b0;
    seed  = 4'h0;
    cycle();
  endtask

  task automatic test_basic();
    logic [3:0] exp [4];
    exp = '{4'h1, 4'h2, 4'h4, 4'h9};
    start = 1'b1; seed = 4'h1; len = 4'h4;
    collect(20, -1, 0, 1'b0);
    vectors++; if (got_n != 4) begin errors++; $display("FAIL basic_count: got %0d want 4", got_n); end
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (got_words[i] !== exp[i]) begin
        errors++; $display("FAIL basic_word%0d: got %h want %h", i, got_words[i], exp[i]);
      end
    end
    vectors++; if (first_valid_cyc != 3) begin errors++; $display("FAIL basic_latency: got %0d want 3", first_valid_cyc); end
    vectors++; if (done_cyc != 7) begin errors++; $display("FAIL basic_done_cyc: got %0d want 7", done_cyc); end
    vectors++; if (done_count != 1) begin errors++; $display("FAIL basic_done_pulses: got %0d want 1", done_count); end
    vectors++; if (busy_after !== 1'b0) begin errors++; $display("FAIL basic_busy_after: got %b want 0", busy_after); end
    vectors++; if (out_after !== 4'h3) begin errors++; $display("FAIL basic_out_hold: got %h want 3", out_after); end
  endtask

  task automatic test_full_period();
    logic [3:0] exp [16];
    exp = '{4'h1, 4'h2, 4'h4, 4'h9, 4'h3, 4'h6, 4'hD, 4'hA,
            4'h5, 4'hB, 4'h7, 4'hF, 4'hE, 4'hC, 4'h8, 4'h1};
    start = 1'b1; seed = 4'h1; len = 4'h0;
    collect(40, -1, 0, 1'b0);
    vectors++; if (got_n != 16) begin errors++; $display("FAIL full_count: got %0d want 16", got_n); end
    for (int i = 0; i < 16; i++) begin
      vectors++;
      if (got_words[i] !== exp[i]) begin
        errors++; $display("FAIL full_word%0d: got %h want %h", i, got_words[i], exp[i]);
      end
    end
    vectors++; if (done_cyc != 19) begin errors++; $display("FAIL full_done_cyc: got %0d want 19", done_cyc); end
    vectors++; if (done_count != 1) begin errors++; $display("FAIL full_done_pulses: got %0d want 1", done_count); end
  endtask

  task automatic test_seed_zero();
    start = 1'b1; seed = 4'h0; len = 4'h4;
    cycle();
    start = 1'b0;
    vectors++; if (err !== 1'b1) begin errors++; $display("FAIL zero_err: got %b want 1", err); end
    vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL zero_busy: got %b want 0", busy); end
    vectors++; if (done !== 1'b0) begin errors++; $display("FAIL zero_done: got %b want 0", done); end
    for (int i = 0; i < 3; i++) begin
      cycle();
      vectors++;
      if (out_valid !== 1'b0 || busy !== 1'b0 || err !== 1'b1) begin
        errors++;
        $display("FAIL zero_idle%0d: got valid=%b busy=%b err=%b want 0 0 1", i, out_valid, busy, err);
      end
    end
    start = 1'b1; seed = 4'h3; len = 4'h1;
    collect(12, -1, 0, 1'b0);
    vectors++; if (err !== 1'b0) begin errors++; $display("FAIL zero_err_clear: got %b want 0", err); end
    vectors++; if (got_n != 1) begin errors++; $display("FAIL zero_restart_count: got %0d want 1", got_n); end
    vectors++; if (got_words[0] !== 4'h3) begin errors++; $display("FAIL zero_restart_word: got %h want 3", got_words[0]); end
    vectors++; if (done_count != 1) begin errors++; $display("FAIL zero_restart_done: got %0d want 1", done_count); end
  endtask

  task automatic test_pause();
    logic [3:0] exp [4];
    exp = '{4'h1, 4'h2, 4'h4, 4'h9};
    // Pause after the second word.
    start = 1'b1; seed = 4'h1; len = 4'h4;
    collect(30, 2, 3, 1'b0);
    vectors++; if (got_n != 4) begin errors++; $display("FAIL pause_count: got %0d want 4", got_n); end
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (got_words[i] !== exp[i]) begin
        errors++; $display("FAIL pause_word%0d: got %h want %h", i, got_words[i], exp[i]);
      end
    end
    vectors++; if (done_cyc != 10) begin errors++; $display("FAIL pause_done_cyc: got %0d want 10", done_cyc); end
    // Pause on the final word pushes done back.
    start = 1'b1; seed = 4'h1; len = 4'h4;
    collect(30, 3, 2, 1'b0);
    vectors++; if (got_n != 4 || got_words[3] !== 4'h9) begin
      errors++; $display("FAIL pause_last_word: got n=%0d w=%h want n=4 w=9", got_n, got_words[3]);
    end
    vectors++; if (done_cyc != 9) begin errors++; $display("FAIL pause_last_done: got %0d want 9", done_cyc); end
  endtask

  task automatic test_back_to_back_start();
    logic [3:0] exp [4];
    exp = '{4'h1, 4'h2, 4'h4, 4'h9};
    // start with seed 5 held high throughout the busy window must be ignored.
    start = 1'b1; seed = 4'h1; len = 4'h4;
    collect(20, -1, 0, 1'b1);
    vectors++; if (got_n != 4) begin errors++; $display("FAIL b2b_count: got %0d want 4", got_n); end
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (got_words[i] !== exp[i]) begin
        errors++; $display("FAIL b2b_word%0d: got %h want %h", i, got_words[i], exp[i]);
      end
    end
    vectors++; if (done_cyc != 7) begin errors++; $display("FAIL b2b_done_cyc: got %0d want 7", done_cyc); end
    vectors++; if (err !== 1'b0) begin errors++; $display("FAIL b2b_err: got %b want 0", err); end
  endtask

  task automatic test_reset_mid_run();
    start = 1'b1; seed = 4'h1; len = 4'h4;
    cycle();
    start = 1'b0;
    for (int i = 0; i < 4; i++) cycle();
    vectors++; if (out_valid !== 1'b1 || out !== 4'h4) begin
      errors++; $display("FAIL midrst_word3: got valid=%b out=%h want 1 4", out_valid, out);
    end
    rst = 1'b1;
    cycle();
    vectors++; if (out !== 4'h0) begin errors++; $display("FAIL midrst_out: got %h want 0", out); end
    vectors++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid: got %b want 0", out_valid); end
    vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b want 0", busy); end
    vectors++; if (done !== 1'b0) begin errors++; $display("FAIL midrst_done: got %b want 0", done); end
    rst   = 1'b0;
    start = 1'b1; seed = 4'h3; len = 4'h2;
    collect(20, -1, 0, 1'b0);
    vectors++; if (got_n != 2 || got_words[0] !== 4'h3 || got_words[1] !== 4'h6) begin
      errors++;
      $display("FAIL midrst_restart: got n=%0d %h %h want n=2 3 6", got_n, got_words[0], got_words[1]);
    end
    vectors++; if (first_valid_cyc != 3) begin errors++; $display("FAIL midrst_latency: got %0d want 3", first_valid_cyc); end
    vectors++; if (done_count != 1) begin errors++; $display("FAIL midrst_done_pulses: got %0d want 1", done_count); end
  endtask

  initial begin
    vectors = 0;
    errors  = 0;
    rst     = 1'b1;
    start   = 1'b0;
    seed    = 4'h0;
    len     = 4'h0;
    pause   = 1'b0;
    test_reset();
    test_basic();
    test_full_period();
    test_seed_zero();
    test_pause();
    test_back_to_back_start();
    test_reset_mid_run();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/lfsr_ctrl.md
LFSR_CTRL -- requirements
Module: lfsr_ctrl

Interface
REQ-001 SHALL have port: clk  input  1  sole clock; all state updates on rising edge.
REQ-002 SHALL have port: rst  input  1  synchronous, active-high reset.
REQ-003 SHALL have port: start  input  1  request a run; sampled only in IDLE.
REQ-004 SHALL have port: seed  input  4  LFSR start value, captured when start is accepted.
REQ-005 SHALL have port: len  input  4  words to emit, captured with seed; 0 means 16.
REQ-006 SHALL have port: pause  input  1  stall RUN: hold LFSR and count, suppress out_valid.
REQ-007 SHALL have port: busy  output  1  high in LOAD, RUN, DONE.
REQ-008 SHALL have port: out  output  4  current LFSR register value.
REQ-009 SHALL have port: out_valid  output  1  out is a valid sequence word this cycle.
REQ-010 SHALL have port: done  output  1  one-cycle pulse after last word.
REQ-011 SHALL have port: err  output  1  sticky; set when start is rejected for seed==0.

Function
REQ-012 SHALL implement Fibonacci LFSR x^4+x^3+1: next = {q[2:0], q[3]^q[2]}; period 15 for any nonzero seed.
REQ-013 SHALL use FSM states IDLE, LOAD, RUN, DONE.
REQ-014 SHALL, in IDLE with start=1 and seed!=0, go to LOAD, capture seed and len (0 -> 16, 5-bit count), clear err.
REQ-015 SHALL, in IDLE with start=1 and seed==0, set err=1, stay IDLE, leave busy and done low.
REQ-016 SHALL, in LOAD, write captured seed into the LFSR and go to RUN next cycle.
REQ-017 SHALL drive out_valid = (state==RUN) && !pause, combinationally from registered state.
REQ-018 SHALL, per RUN cycle with out_valid=1, advance the LFSR one step and decrement the count.
REQ-019 SHALL, when the word emitted has count==1, go to DONE; first word emitted equals seed.
REQ-020 SHALL assert done for exactly the one DONE cycle, then return to IDLE.
REQ-021 SHALL give latency: start accepted at edge k -> first out_valid in the cycle after edge k+2.
REQ-022 SHALL ignore start outside IDLE, with no effect on seed, len, count or err.
REQ-023 SHALL hold out at last LFSR value in IDLE and DONE; out_valid low there.
REQ-024 SHALL let pause have no effect outside RUN; pause on the final word delays DONE until it is emitted.
REQ-025 SHALL, with len=0, emit 16 words; the 16th word repeats the seed (wrap of the period).

Reset
REQ-026 SHALL, on rst=1 at a clock edge, force IDLE, LFSR=0, count=0, out=0, out_valid=0, busy=0, done=0, err=0.
REQ-027 SHALL give rst priority over start and pause; reset mid-RUN aborts with no done pulse.
REQ-028 SHALL accept a new start on the first cycle after rst deasserts.

Structure
REQ-029 SHALL place the FSM state enum, LFSR_W=4, TAP mask 4'b1100 and COUNT_W=5 in shared package lfsr_pkg.
REQ-030 SHALL instantiate one sub-module lfsr_core (4-bit register with load, enable, step) under the FSM/counter.

Verification
REQ-031 SHALL cover: seed=0001, len=4 -> out_valid words 1,2,4,9, then done pulse 1 cycle, busy low after.
REQ-032 SHALL cover: seed=0001, len=0 -> 16 words 1,2,4,9,3,6,D,A,5,B,7,F,E,C,8,1; no 0 word.
REQ-033 SHALL cover: seed=0000, start=1 -> err=1, busy=0, no out_valid; next start seed=0011 -> err=0, first word 3.
REQ-034 SHALL cover: seed=0001, len=4, pause=1 for 3 cycles after word 2 -> words still 1,2,4,9; done 3 cycles later.
REQ-035 SHALL cover: rst=1 during word 3 of seed=0001 run -> all outputs 0 next cycle, no done; restart works.
REQ-036 SHALL cover: start pulsed while busy with seed=0101 -> ignored; current run completes unchanged.
